// File: rtl/spi_slave_shifter.sv
// Slave-side SPI endpoint. SCK, CSn and MOSI are oversampled in the CLK domain.
// Words are shifted in on MOSI and out on MISO, with a single-word transmit holding register.
module spi_slave_shifter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCK,
  input  logic                  CSn,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [DATA_WIDTH-1:0] Tx_Data,
  input  logic                  Tx_Load,
  output logic                  Tx_Ready,
  output logic [DATA_WIDTH-1:0] Rx_Data,
  output logic                  Rx_Valid,
  output logic                  Frame_Err
);

  localparam int unsigned         CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Bit order helpers shared by the transmit and receive paths.
  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] drop_lead(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] push_bit(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers: index 0 = flop 1, 1 = flop 2, 2 = edge-detect flop.
  // ---------------------------------------------------------------------------
  logic [2:0] sck_q;
  logic [2:0] csn_q;
  logic [1:0] mosi_q;

  // CSn sync flops reset to "low" so that a master still holding CSn low when
  // RST is released is not seen as a fresh falling edge mid-frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_q  <= {3{CPOL}};
      csn_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make every flop capture the previous
      // stage's old value, which is what turns this into a shift chain.
      sck_q  <= {sck_q[1:0], SCK};
      csn_q  <= {csn_q[1:0], CSn};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  logic sck_lead, sck_trail, sample_edge, shift_edge;
  logic csn_fall, csn_rise;

  assign sck_lead    = (sck_q[1] != CPOL) && (sck_q[2] == CPOL);
  assign sck_trail   = (sck_q[1] == CPOL) && (sck_q[2] != CPOL);
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign shift_edge  = CPHA ? sck_lead  : sck_trail;
  assign csn_fall    = !csn_q[1] &&  csn_q[2];
  assign csn_rise    =  csn_q[1] && !csn_q[2];

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   active;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default assignment on every path keeps combinational blocks
    // free of inferred latches.
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (csn_fall) state_d = ACTIVE;
      ACTIVE: if (csn_rise) state_d = IDLE;
    endcase
  end

  always_comb begin
    active  = (state_q == ACTIVE);
    MISO_OE = active;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] hold_q,    hold_d;
  logic                  ready_q,   ready_d;
  logic [DATA_WIDTH-1:0] tx_sh_q,   tx_sh_d;
  logic                  miso_q,    miso_d;
  logic [DATA_WIDTH-1:0] rx_sh_q,   rx_sh_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;

  logic                  word_done;
  logic                  start_on_fall;
  logic                  word_start;
  logic [DATA_WIDTH-1:0] next_word;

  assign word_done     = (cnt_q == CNT_FULL);
  assign start_on_fall = (state_q == IDLE) && csn_fall;
  assign word_start    = start_on_fall || (active && word_done);
  assign next_word     = ready_q ? '0 : hold_q;

  // Holding register: word start empties it, an accepted load fills it; a load
  // in the word-start cycle lands after the copy has taken the old content.
  always_comb begin
    hold_d  = hold_q;
    ready_d = ready_q;
    if (word_start) ready_d = 1'b1;
    if (Tx_Load && ready_q) begin
      hold_d  = Tx_Data;
      ready_d = 1'b0;
    end
  end

  // Transmit: with CPHA=0 the first bit must already be on MISO before the
  // first sample edge, so a CSn-fall start drives it immediately. Otherwise
  // the word is parked and the next shift edge presents its first bit.
  always_comb begin
    tx_sh_d = tx_sh_q;
    miso_d  = miso_q;
    if (word_start) begin
      if (start_on_fall && !CPHA) begin
        miso_d  = lead_bit(next_word);
        tx_sh_d = drop_lead(next_word);
      end else begin
        tx_sh_d = next_word;
      end
    end else if (active && shift_edge) begin
      miso_d  = lead_bit(tx_sh_q);
      tx_sh_d = drop_lead(tx_sh_q);
    end
  end

  // Receive and framing.
  always_comb begin
    rx_sh_d     = rx_sh_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (word_done) begin
      rx_data_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      cnt_d      = '0;
    end else if (active && sample_edge) begin
      rx_sh_d = push_bit(rx_sh_q, mosi_q[1]);
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (start_on_fall) cnt_d = '0;
    if (active && csn_rise) begin
      cnt_d       = '0;
      frame_err_d = (cnt_q != '0) && !word_done;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q      <= '0;
      ready_q     <= 1'b1;
      tx_sh_q     <= '0;
      miso_q      <= 1'b0;
      rx_sh_q     <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
      rx_sh_q     <= rx_sh_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = miso_q;
  assign Tx_Ready  = ready_q;
  assign Rx_Data   = rx_data_q;
  assign Rx_Valid  = rx_valid_q;
  assign Frame_Err = frame_err_q;

endmodule
